instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-core matrix multiplier: the read-side initiator for the byte-wide instruction memory. It walks the program counter, drives the memory read address, absorbs the memory's one-cycle registered read latency, and assembles variable-length instructions (opcode byte plus an optional immediate byte) into a single record. Each record is handed to the control unit over a valid/ready handshake, and the unit accepts jump redirects and stops at ENDOP.

## Interface
- DATA_WIDTH, 8, instruction byte width
- ADDR_WIDTH, 8, instruction address width (program space 2**ADDR_WIDTH bytes)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begin fetching at address 0 (honoured only in IDLE or HALT)
- mem_we  input  1  instruction memory write in progress; the memory performs no read in that cycle
- r_addr  output  ADDR_WIDTH  read address to instruction memory
- r_instr  input  DATA_WIDTH  registered read data from memory, valid the cycle after r_addr is presented with mem_we=0
- instr_valid  output  1  opcode/operand/has_operand/instr_pc hold a complete instruction
- instr_ready  input  1  control unit accepts the instruction
- opcode  output  DATA_WIDTH  opcode byte
- operand  output  DATA_WIDTH  immediate byte; 0 when has_operand=0
- has_operand  output  1  instruction is two bytes
- instr_pc  output  ADDR_WIDTH  address of the opcode byte
- jump_en  input  1  redirect fetch to jump_addr
- jump_addr  input  ADDR_WIDTH  redirect target
- halted  output  1  ENDOP accepted; fetching stopped

## Operation
- Two-byte opcodes: LDACI=0, STACI=13, JPNZ=27. All other opcode values, including undefined ones, are one byte. ENDOP=28.
- States:
  - IDLE
  - OP_RD: r_addr=pc
  - OP_CAP: latch opcode=r_instr, instr_pc=pc
  - ARG_RD: r_addr=pc+1
  - ARG_CAP: latch operand=r_instr
  - PRESENT
  - HALT
- r_addr = pc in IDLE, OP_RD, OP_CAP, PRESENT and HALT; pc+1 (mod 2**ADDR_WIDTH) in ARG_RD and ARG_CAP.
- IDLE/HALT --start--> OP_RD with pc=0; halted clears on start.
- OP_RD --mem_we=0--> OP_CAP; if mem_we=1, stay in OP_RD.
- OP_CAP --> ARG_RD if the opcode is two-byte; otherwise --> PRESENT with operand=0 and has_operand=0.
- ARG_RD --mem_we=0--> ARG_CAP; if mem_we=1, stay in ARG_RD.
- ARG_CAP --> PRESENT with has_operand=1.
- PRESENT: instr_valid=1; outputs stay stable until instr_valid && instr_ready.
- On handshake:
  - If opcode=ENDOP: go to HALT and set halted=1.
  - Otherwise: pc += 1 or 2 (wraps mod 2**ADDR_WIDTH), then go to OP_RD.
- jump_en in any state other than IDLE/HALT:
  - pc <= jump_addr, go to OP_RD, instr_valid=0 next cycle.
  - Any partially fetched or presented instruction is discarded.
  - jump_en takes priority over a simultaneous handshake.
- jump_en is ignored in IDLE and HALT. start is ignored in all other states.
- The memory write port is never driven by this block.

## Timing
- Reset, asynchronous: state=IDLE, pc=0, r_addr=0, instr_valid=0, opcode=0, operand=0, has_operand=0, instr_pc=0, halted=0.
- Latency from entering OP_RD to instr_valid, with mem_we=0:
  - one-byte instruction: 2 cycles
  - two-byte instruction: 4 cycles
- Each cycle of mem_we=1 in a *_RD state adds one cycle. mem_we in the CAP states has no effect.
- Throughput with instr_ready tied high:
  - one-byte instructions: one per 3 cycles
  - two-byte instructions: one per 5 cycles
- A jump asserted in cycle N puts jump_addr on r_addr in cycle N+1 (OP_RD).
- An ENDOP handshake in cycle N gives halted=1 and instr_valid=0 from cycle N+1. r_addr is frozen in HALT.
- Address wrap: a two-byte opcode at 255 reads its operand from 0. pc then becomes 1.
- rst asserted mid-fetch returns the unit immediately to reset values. Fetching does not resume until start.

## Test plan
- Program {24, 26, 28} at 0, instr_ready=1, start: three records are presented: (24, pc 0), (26, pc 1), (28, pc 2). Each has has_operand=0 and valid 2 cycles after its OP_RD. halted=1 after the third. No further r_addr change.
- Program {0, 9, 13, 1, 28}: records are (0, 9, pc 0) and (13, 1, pc 2), both with has_operand=1, then ENDOP at pc 4. instr_valid rises 4 cycles after each OP_RD.
- Hold instr_ready=0 for 5 cycles on the first record: outputs and r_addr stay stable. Exactly one record is accepted when ready rises.
- JPNZ 50 accepted, then jump_en=1 with jump_addr=50 in the next cycle: r_addr=50 in the following cycle. The instruction at pc 2 is never presented.
- Pulse mem_we for 3 cycles while in OP_RD: OP_CAP is entered only after mem_we falls. The opcode captured is the byte at pc.
- Assert rst while in ARG_CAP: all outputs read their reset values in the same cycle. start afterwards fetches from 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Purpose : instruction fetch unit. Walks the PC over a byte-wide memory with a
//           one-cycle registered read, assembles opcode plus optional immediate
//           into one record, and offers it to the control unit.
// Latency : OP_RD entry to instr_valid is 2 cycles for one-byte instructions and
//           4 cycles for two-byte instructions. Each mem_we cycle in a read state adds one.
// Backpressure: a record stays stable in PRESENT until instr_ready is seen.
//           jump_en overrides everything except IDLE/HALT.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin fetching at address 0 (IDLE/HALT only)
//   mem_we                   memory busy writing; no read happens this cycle
//   r_addr / r_instr         memory read address / data (data one cycle later)
//   instr_valid/instr_ready  record handshake to the control unit
//   opcode, operand, has_operand, instr_pc   record contents
//   jump_en, jump_addr       fetch redirect
//   halted                   ENDOP accepted
module instr_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  has_operand,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  halted
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OP_RD   = 3'd1;
    localparam logic [2:0] S_OP_CAP  = 3'd2;
    localparam logic [2:0] S_ARG_RD  = 3'd3;
    localparam logic [2:0] S_ARG_CAP = 3'd4;
    localparam logic [2:0] S_PRESENT = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    localparam logic [DATA_WIDTH-1:0] OP_LDACI = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] OP_STACI = DATA_WIDTH'(13);
    localparam logic [DATA_WIDTH-1:0] OP_JPNZ  = DATA_WIDTH'(27);
    localparam logic [DATA_WIDTH-1:0] OP_ENDOP = DATA_WIDTH'(28);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  two_byte;

    // Decoded straight off the memory data while in OP_CAP.
    assign two_byte = (r_instr == OP_LDACI) || (r_instr == OP_STACI) ||
                      (r_instr == OP_JPNZ);

    // The operand byte lives at pc+1; the address wraps naturally.
    assign r_addr = ((state == S_ARG_RD) || (state == S_ARG_CAP)) ?
                    pc + ADDR_WIDTH'(1) : pc;

    assign instr_valid = (state == S_PRESENT);
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            opcode      <= '0;
            operand     <= '0;
            has_operand <= 1'b0;
            instr_pc    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_OP_RD;
                    end
                end
                default: begin
                    // A redirect discards whatever is partially fetched or on offer,
                    // and it wins over a handshake in the same cycle.
                    if (jump_en) begin
                        pc    <= jump_addr;
                        state <= S_OP_RD;
                    end else begin
                        case (state)
                            S_OP_RD: begin
                                if (!mem_we) state <= S_OP_CAP;
                            end
                            S_OP_CAP: begin
                                opcode   <= r_instr;
                                instr_pc <= pc;
                                if (two_byte) begin
                                    state <= S_ARG_RD;
                                end else begin
                                    operand     <= '0;
                                    has_operand <= 1'b0;
                                    state       <= S_PRESENT;
                                end
                            end
                            S_ARG_RD: begin
                                if (!mem_we) state <= S_ARG_CAP;
                            end
                            S_ARG_CAP: begin
                                operand     <= r_instr;
                                has_operand <= 1'b1;
                                state       <= S_PRESENT;
                            end
                            S_PRESENT: begin
                                if (instr_ready) begin
                                    if (opcode == OP_ENDOP) begin
                                        state <= S_HALT;
                                    end else begin
                                        pc    <= pc + (has_operand ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
                                        state <= S_OP_RD;
                                    end
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_we;
    logic [7:0] r_addr;
    logic [7:0] r_instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic       has_operand;
    logic [7:0] instr_pc;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halted;

    instr_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_we      (mem_we),
        .r_addr      (r_addr),
        .r_instr     (r_instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .has_operand (has_operand),
        .instr_pc    (instr_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory model: registered read, no read while mem_we is high.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (!mem_we) r_instr <= mem[r_addr];
    end

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic       has;
        logic [7:0] pc;
        int         lat;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] arg,
                        input logic has, input logic [7:0] pc);
        rec_t r;
        r.op  = op;
        r.arg = arg;
        r.has = has;
        r.pc  = pc;
        r.lat = has ? 4 : 2;
        exp_q.push_back(r);
    endtask

    // Called in an OP_RD cycle; counts cycles until a record is offered.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < 40);
    endtask

    // Check the next offered record against the scoreboard (no handshake here).
    task automatic expect_record(input string tag);
        int   n;
        rec_t r;
        wait_valid(n);
        chk({tag, "_valid"}, instr_valid, 1'b1);
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk({tag, "_latency"}, n, r.lat);
            chk({tag, "_opcode"}, opcode, r.op);
            chk({tag, "_operand"}, operand, r.arg);
            chk({tag, "_has_operand"}, has_operand, r.has);
            chk({tag, "_instr_pc"}, instr_pc, r.pc);
        end
    endtask

    // Check and accept (instr_ready must already be 1).
    task automatic take(input string tag);
        expect_record(tag);
        tick();
    endtask

    task automatic start_fetch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_halted(input string tag);
        logic [7:0] a;
        chk({tag, "_halted"}, halted, 1'b1);
        chk({tag, "_valid_low"}, instr_valid, 1'b0);
        a = r_addr;
        repeat (3) tick();
        chk({tag, "_raddr_frozen"}, r_addr, a);
        chk({tag, "_still_halted"}, halted, 1'b1);
    endtask

    initial begin
        logic [7:0] snap_op, snap_addr;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        rst = 1'b1; start = 1'b0; mem_we = 1'b0; instr_ready = 1'b1;
        jump_en = 1'b0; jump_addr = 8'h00;
        tick(); tick();
        chk("rst_raddr", r_addr, 8'h00);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_opcode", opcode, 8'h00);
        chk("rst_operand", operand, 8'h00);
        chk("rst_has_operand", has_operand, 1'b0);
        chk("rst_instr_pc", instr_pc, 8'h00);
        chk("rst_halted", halted, 1'b0);
        rst = 1'b0;
        tick();
        // start is needed; nothing happens on its own
        chk("idle_no_fetch", instr_valid, 1'b0);

        // One-byte program
        mem[0] = 8'd24; mem[1] = 8'd26; mem[2] = 8'd28;
        push(8'd24, 8'd0, 1'b0, 8'd0);
        push(8'd26, 8'd0, 1'b0, 8'd1);
        push(8'd28, 8'd0, 1'b0, 8'd2);
        start_fetch();
        chk("t1_raddr_oprd", r_addr, 8'd0);
        take("t1_r0");
        chk("t1_raddr_pc1", r_addr, 8'd1);
        take("t1_r1");
        take("t1_r2");
        check_halted("t1");
        chk("t1_raddr_end", r_addr, 8'd2);

        // Two-byte program
        mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd13; mem[3] = 8'd1; mem[4] = 8'd28;
        push(8'd0, 8'd9, 1'b1, 8'd0);
        push(8'd13, 8'd1, 1'b1, 8'd2);
        push(8'd28, 8'd0, 1'b0, 8'd4);
        start_fetch();
        take("t2_r0");
        take("t2_r1");
        take("t2_r2");
        check_halted("t2");

        // Backpressure: hold ready low for 5 cycles on the first record
        push(8'd0, 8'd9, 1'b1, 8'd0);
        instr_ready = 1'b0;
        start_fetch();
        expect_record("t3_r0");
        snap_op = opcode;
        snap_addr = r_addr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", instr_valid, 1'b1);
            chk("t3_hold_opcode", opcode, snap_op);
            chk("t3_hold_operand", operand, 8'd9);
            chk("t3_hold_raddr", r_addr, snap_addr);
        end
        instr_ready = 1'b1;
        tick();
        chk("t3_after_hs_valid", instr_valid, 1'b0);
        chk("t3_after_hs_raddr", r_addr, 8'd2);
        push(8'd13, 8'd1, 1'b1, 8'd2);
        push(8'd28, 8'd0, 1'b0, 8'd4);
        take("t3_r1");
        take("t3_r2");
        check_halted("t3");

        // Jump after JPNZ; the instruction at pc 2 is skipped
        mem[0] = 8'd27; mem[1] = 8'd50; mem[2] = 8'd5; mem[50] = 8'd28;
        push(8'd27, 8'd50, 1'b1, 8'd0);
        push(8'd28, 8'd0, 1'b0, 8'd50);
        start_fetch();
        take("t4_jpnz");
        chk("t4_raddr_pc2", r_addr, 8'd2);
        jump_en = 1'b1; jump_addr = 8'd50;
        tick();
        jump_en = 1'b0;
        chk("t4_jump_raddr", r_addr, 8'd50);
        chk("t4_jump_valid", instr_valid, 1'b0);
        take("t4_target");
        check_halted("t4");

        // mem_we stalls OP_RD; stale memory data (28) must not be captured
        mem[0] = 8'd5; mem[1] = 8'd28;
        push(8'd5, 8'd0, 1'b0, 8'd0);
        push(8'd28, 8'd0, 1'b0, 8'd1);
        start_fetch();
        mem_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stall_valid", instr_valid, 1'b0);
            chk("t5_stall_raddr", r_addr, 8'd0);
        end
        mem_we = 1'b0;
        take("t5_r0");
        take("t5_r1");
        check_halted("t5");

        // Reset in ARG_CAP
        mem[0] = 8'd13; mem[1] = 8'd7; mem[2] = 8'd28;
        start_fetch();
        tick(); tick(); tick();
        chk("t6_argcap_raddr", r_addr, 8'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_raddr", r_addr, 8'd0);
        chk("t6_rst_valid", instr_valid, 1'b0);
        chk("t6_rst_opcode", opcode, 8'd0);
        chk("t6_rst_operand", operand, 8'd0);
        chk("t6_rst_has_operand", has_operand, 1'b0);
        chk("t6_rst_halted", halted, 1'b0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("t6_no_resume_valid", instr_valid, 1'b0);
            chk("t6_no_resume_raddr", r_addr, 8'd0);
        end
        push(8'd13, 8'd7, 1'b1, 8'd0);
        push(8'd28, 8'd0, 1'b0, 8'd2);
        start_fetch();
        take("t6_r0");
        take("t6_r1");
        check_halted("t6");

        // Address wrap: two-byte opcode at 255 takes its operand from 0
        mem[255] = 8'd13; mem[0] = 8'd44; mem[1] = 8'd28;
        push(8'd13, 8'd44, 1'b1, 8'd255);
        push(8'd28, 8'd0, 1'b0, 8'd1);
        start_fetch();
        jump_en = 1'b1; jump_addr = 8'd255;
        tick();
        jump_en = 1'b0;
        chk("t7_jump_raddr", r_addr, 8'd255);
        take("t7_r0");
        chk("t7_wrap_raddr", r_addr, 8'd1);
        take("t7_r1");
        check_halted("t7");

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
